// File: rtl/seg_pkg.sv
// Shared types and seven-segment helpers for the counter display slice.
// Segment patterns are active-low, bit 6 = g ... bit 0 = a.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter.
// Snapshots bin whenever it differs from the last converted value.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  conv_state_t         state, state_nxt;
  logic [WIDTH-1:0]    snap;
  logic [WIDTH-1:0]    bin_sr;
  logic [4*DIGITS-1:0] bcd_sr;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [CNT_W-1:0]    bit_cnt;
  logic                last_bit;

  always_comb begin
    bcd_adj = bcd_sr;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && (bin != snap)) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      snap    <= '0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (state_nxt == SHIFT) begin
            snap    <= bin;
            bin_sr  <= bin;
            bcd_sr  <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          bcd_sr  <= {bcd_adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
          bin_sr  <= bin_sr << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Busy also covers the idle cycle where bin has moved but is not yet captured.
  assign busy = (state != IDLE) || (bin != snap);
  assign done = (state == DONE);
  assign bcd  = bcd_sr;

endmodule

// File: rtl/seg_counter_display.sv
// Up/down counter with parallel load, driven to multiplexed active-low
// seven-segment digits through a sequential BCD converter.
module seg_counter_display
  import seg_pkg::*;
#(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned BLANK_LZ = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                up,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  output logic [WIDTH-1:0]    count,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   dig_sel
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic                conv_busy;
  logic                conv_done;
  logic [4*DIGITS-1:0] conv_bcd;
  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    dig_idx;
  logic [DIGITS-1:0]   sel_onehot;
  logic [DIGITS-1:0]   zero_above;
  logic [DIGITS-1:0]   blank_mask;
  logic                run_zero;
  logic [3:0]          cur_nib;
  logic                cur_blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (tick)
      count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
  end

  // The converter compares against its own snapshot, so it is always enabled.
  bin2bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (1'b1),
    .bin   (count),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bcd <= '0;
    else if (conv_done)
      bcd <= conv_bcd;
  end

  assign bcd_valid = ~conv_busy;

  always_comb begin
    zero_above = '0;
    run_zero   = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      run_zero                  = run_zero && (bcd[4*(DIGITS-1-j) +: 4] == 4'd0);
      zero_above[DIGITS-1-j]    = run_zero;
    end
    blank_mask = (BLANK_LZ != 0) ? (zero_above & ~DIGITS'(1)) : '0;
  end

  assign sel_onehot = DIGITS'(1) << dig_idx;

  always_comb begin
    cur_nib = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (32'(dig_idx) == i)
        cur_nib = bcd[4*i +: 4];
    end
    cur_blank = |(blank_mask & sel_onehot);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      dig_idx <= (dig_idx == IDX_W'(DIGITS - 1)) ? '0 : dig_idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg     <= SEG_0;
      dig_sel <= ~DIGITS'(1);
    end else begin
      seg     <= cur_blank ? SEG_BLANK : seg_decode(cur_nib);
      dig_sel <= ~sel_onehot;
    end
  end

endmodule

// File: tb/tb_seg_counter_display.sv
// Scoreboarded bench for seg_counter_display: two instances share stimulus,
// the second one with leading-zero blanking enabled.
module tb_seg_counter_display;

  localparam logic [6:0] P0    = 7'b1000000;
  localparam logic [6:0] P1    = 7'b1111001;
  localparam logic [6:0] P3    = 7'b0110000;
  localparam logic [6:0] P6    = 7'b0000010;
  localparam logic [6:0] P7    = 7'b1111000;
  localparam logic [6:0] PBLK  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [5:0] load_val = '0;

  logic [5:0] count, b_count;
  logic [7:0] bcd, b_bcd;
  logic       bcd_valid, b_bcd_valid;
  logic [6:0] seg, b_seg;
  logic [1:0] dig_sel, b_dig_sel;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  int model_count = 0;

  always #5 clk = ~clk;

  seg_counter_display #(.WIDTH(6), .DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(0)) dut (
    .clk(clk), .rst(rst), .tick(tick), .up(up), .load(load), .load_val(load_val),
    .count(count), .bcd(bcd), .bcd_valid(bcd_valid), .seg(seg), .dig_sel(dig_sel)
  );

  seg_counter_display #(.WIDTH(6), .DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(1)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .up(up), .load(load), .load_val(load_val),
    .count(b_count), .bcd(b_bcd), .bcd_valid(b_bcd_valid), .seg(b_seg), .dig_sel(b_dig_sel)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    load_val = 6'(v);
    load = 1'b1;
    cycle();
    load = 1'b0;
    model_count = v;
    exp_q.push_back(to_bcd(model_count));
  endtask

  task automatic do_ticks(input logic dir, input int n);
    up = dir;
    tick = 1'b1;
    for (int i = 0; i < n; i++) begin
      cycle();
      model_count = dir ? (model_count + 1) % 64 : (model_count + 63) % 64;
      exp_q.push_back(to_bcd(model_count));
    end
    tick = 1'b0;
  endtask

  task automatic wait_result(output logic [7:0] exp, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bcd_valid) begin
        timed_out = 1'b0;
        break;
      end
      cycle();
    end
    exp = 8'hxx;
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    if (exp_q.size() == 0) timed_out = 1'b1;
    else exp = exp_q.pop_front();
  endtask

  task automatic wait_digit(input logic [1:0] target, output bit ok);
    logic [1:0] prev;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      prev = dig_sel;
      cycle();
      if (dig_sel == target && prev != target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    #1;
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (bcd !== 8'h00) begin n_fail++; $display("FAIL reset_bcd: got %h expected 00", bcd); end
    n_checks++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL reset_valid: got %b expected 1", bcd_valid); end
    n_checks++; if (dig_sel !== 2'b10) begin n_fail++; $display("FAIL reset_dig_sel: got %b expected 10", dig_sel); end
    n_checks++; if (seg !== P0) begin n_fail++; $display("FAIL reset_seg: got %b expected %b", seg, P0); end
  endtask

  task automatic test_load_max();
    logic [7:0] exp;
    bit ok;
    bit early;
    do_load(63);
    n_checks++; if (bcd_valid !== 1'b0) begin n_fail++; $display("FAIL max_valid_drop: got %b expected 0", bcd_valid); end
    early = 1'b0;
    for (int i = 1; i < 8; i++) begin
      cycle();
      if (bcd !== 8'h00) early = 1'b1;
    end
    n_checks++; if (early) begin n_fail++; $display("FAIL max_latency_early: got bcd %h before cycle 8 expected 00", bcd); end
    cycle();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_checks++; if (bcd !== exp) begin n_fail++; $display("FAIL max_bcd_cycle8: got %h expected %h", bcd, exp); end
    n_checks++; if (bcd_valid !== 1'b1) begin n_fail++; $display("FAIL max_valid_rise: got %b expected 1", bcd_valid); end
    wait_digit(2'b10, ok);
    n_checks++; if (!ok || seg !== P3) begin n_fail++; $display("FAIL max_digit0_seg: got %b sel %b expected %b sel 10", seg, dig_sel, P3); end
    repeat (4) cycle();
    n_checks++; if (dig_sel !== 2'b01) begin n_fail++; $display("FAIL max_scan_step: got %b expected 01", dig_sel); end
    n_checks++; if (seg !== P6) begin n_fail++; $display("FAIL max_digit1_seg: got %b expected %b", seg, P6); end
  endtask

  task automatic test_load_ten();
    logic [7:0] exp;
    bit to, ok;
    do_load(10);
    wait_result(exp, to);
    n_checks++; if (to || bcd !== exp) begin n_fail++; $display("FAIL ten_bcd: got %h valid %b expected %h", bcd, bcd_valid, exp); end
    wait_digit(2'b01, ok);
    n_checks++; if (!ok || seg !== P1) begin n_fail++; $display("FAIL ten_digit1_seg: got %b expected %b", seg, P1); end
    wait_digit(2'b10, ok);
    n_checks++; if (!ok || seg !== P0) begin n_fail++; $display("FAIL ten_digit0_seg: got %b expected %b", seg, P0); end
  endtask

  task automatic test_blanking();
    logic [7:0] exp;
    bit to, ok;
    do_load(7);
    wait_result(exp, to);
    n_checks++; if (to || b_bcd !== exp) begin n_fail++; $display("FAIL blank_bcd: got %h expected %h", b_bcd, exp); end
    wait_digit(2'b01, ok);
    n_checks++; if (!ok || b_seg !== PBLK) begin n_fail++; $display("FAIL blank_digit1: got %b expected %b", b_seg, PBLK); end
    n_checks++; if (seg !== P0) begin n_fail++; $display("FAIL noblank_digit1: got %b expected %b", seg, P0); end
    wait_digit(2'b10, ok);
    n_checks++; if (!ok || b_seg !== P7) begin n_fail++; $display("FAIL blank_digit0: got %b expected %b", b_seg, P7); end
    do_load(0);
    wait_result(exp, to);
    n_checks++; if (to || b_bcd !== exp) begin n_fail++; $display("FAIL blank_zero_bcd: got %h expected %h", b_bcd, exp); end
    wait_digit(2'b10, ok);
    n_checks++; if (!ok || b_seg !== P0) begin n_fail++; $display("FAIL blank_zero_digit0: got %b expected %b", b_seg, P0); end
    wait_digit(2'b01, ok);
    n_checks++; if (!ok || b_seg !== PBLK) begin n_fail++; $display("FAIL blank_zero_digit1: got %b expected %b", b_seg, PBLK); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    bit to;
    do_load(0);
    wait_result(exp, to);
    do_ticks(1'b0, 1);
    wait_result(exp, to);
    n_checks++; if (count !== 6'(model_count)) begin n_fail++; $display("FAIL wrap_down_count: got %0d expected %0d", count, model_count); end
    n_checks++; if (to || bcd !== exp) begin n_fail++; $display("FAIL wrap_down_bcd: got %h expected %h", bcd, exp); end
    do_ticks(1'b1, 1);
    wait_result(exp, to);
    n_checks++; if (count !== 6'(model_count)) begin n_fail++; $display("FAIL wrap_up_count: got %0d expected %0d", count, model_count); end
    n_checks++; if (to || bcd !== exp) begin n_fail++; $display("FAIL wrap_up_bcd: got %h expected %h", bcd, exp); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    bit landed, early_valid, bad;
    do_load(20);
    repeat (2) cycle();
    do_ticks(1'b1, 3);
    exp = exp_q[exp_q.size()-1];
    exp_q.delete();
    landed = 1'b0;
    early_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bcd === exp && bcd_valid) begin
        landed = 1'b1;
        break;
      end
      if (bcd_valid) early_valid = 1'b1;
      cycle();
    end
    n_checks++; if (!landed || bcd !== exp) begin n_fail++; $display("FAIL pending_bcd: got %h expected %h", bcd, exp); end
    n_checks++; if (early_valid) begin n_fail++; $display("FAIL pending_valid: got valid 1 before landing expected 0"); end
    n_checks++; if (count !== 6'(model_count)) begin n_fail++; $display("FAIL pending_count: got %0d expected %0d", count, model_count); end

    do_load(45);
    repeat (3) cycle();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    exp_q.delete();
    model_count = 0;
    exp_q.push_back(to_bcd(0));
    exp = exp_q.pop_front();
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bcd !== exp || bcd_valid !== 1'b1) bad = 1'b1;
      cycle();
    end
    n_checks++; if (bad || bcd !== exp) begin n_fail++; $display("FAIL reset_abort_bcd: got %h valid %b expected %h", bcd, bcd_valid, exp); end
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_abort_count: got %0d expected 0", count); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_max();
    test_load_ten();
    test_blanking();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
